tl_channel_queue: RTL
=====================

Name: tl_channel_queue

Overview:
- Parameterised ready/valid FIFO that sits directly upstream of the single-bit channel pass-through buffers in the E21 tile interconnect.
- Decouples a TileLink-style channel producer from its consumer.
- The consumer side drives the pass-through stage's input; the producer side is the tile's channel source.
- Absorbs backpressure so the producer may issue while the consumer stalls.

Parameters:
- WIDTH, 8, payload width in bits (>=1).
- DEPTH, 2, number of storage entries (>=1; need not be a power of two).

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enq_valid  input  1  producer presents a beat.
- enq_ready  output  1  queue can accept a beat this cycle.
- enq_bits  input  WIDTH  producer payload.
- deq_valid  output  1  queue presents a beat.
- deq_ready  input  1  consumer accepts the beat this cycle.
- deq_bits  output  WIDTH  payload at the head of the queue.
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.

Behaviour:
- Transfers:
  - An enq fire is enq_valid & enq_ready.
  - A deq fire is deq_valid & deq_ready.
  - Both take effect at the rising clock edge.
- State:
  - enq_ptr and deq_ptr, each 0..DEPTH-1.
  - maybe_full flag.
  - Storage array of DEPTH x WIDTH; storage is not reset.
- Pointer wrap:
  - A pointer at DEPTH-1 advances to 0.
  - Wrap uses explicit compare, not modulo-2^n, so non-power-of-two DEPTH works.
- Derived status:
  - empty = (enq_ptr==deq_ptr) & !maybe_full.
  - full = (enq_ptr==deq_ptr) & maybe_full.
- Outputs:
  - enq_ready = !full.
  - deq_valid = !empty.
  - deq_bits = storage[deq_ptr].
- On an enq fire:
  - storage[enq_ptr] <= enq_bits.
  - enq_ptr advances.
- On a deq fire, deq_ptr advances.
- maybe_full update:
  - Set when an enq fire occurs without a deq fire.
  - Cleared when a deq fire occurs without an enq fire.
  - Unchanged when both or neither fire.
- count:
  - If the pointers are equal, count = maybe_full ? DEPTH : 0.
  - Otherwise, count = (enq_ptr - deq_ptr) mod DEPTH.
  - count is combinational from the registers.
- Latency: with the flow feature disabled, a beat written in cycle N is visible on deq in cycle N+1 at the earliest.
- Ordering: strict FIFO; no beat is dropped or duplicated.
- Stability: while deq_valid=1 and deq_ready=0, deq_bits and deq_valid hold until a deq fire.
- Full boundary:
  - enq_ready=0, so an enq attempt is ignored.
  - A simultaneous deq proceeds and frees one slot for the next cycle.
- Empty boundary:
  - deq_valid=0, so deq_ready is ignored.
- Simultaneous enq+deq when partially occupied: count unchanged and both pointers advance.
- DEPTH=1: acts as a single-entry buffer; throughput is one beat per 2 cycles when the consumer is always ready.
- Reset:
  - Any cycle with reset=1 sets enq_ptr=0, deq_ptr=0, maybe_full=0 at the edge.
  - Resetting mid-operation discards all held beats.
  - After reset: enq_ready=1, deq_valid=0, count=0. deq_bits is don't-care.
- No X propagation from storage onto deq_valid, enq_ready or count.

Optional Feature:
- Macro: TL_CHANNEL_QUEUE_FLOW_EN.
- When defined, the queue flows through while empty:
  - If empty & enq_valid, then deq_valid=1 and deq_bits=enq_bits combinationally.
  - If deq_ready is also 1, the beat passes in the same cycle.
  - In that case storage, pointers and maybe_full are not updated, and count stays 0.
  - If deq_ready=0, the beat is written normally.
- When not defined, behaviour is exactly as above, with minimum latency 1 cycle.

Test Plan:
- Reset, then idle -> enq_ready=1, deq_valid=0, count=0.
- DEPTH=2, deq_ready=0, enq 0xA1 then 0xB2 -> count 1 then 2; enq_ready=0 after the second beat; a third enq of 0xC3 is ignored.
- From full, deq_ready=1 with enq_valid=1 and bits 0xC3 -> cycle 1 outputs 0xA1 with the enq blocked; subsequent deq order is 0xB2, 0xC3.
- Continuous enq 0x00..0x0F with deq_ready=1 -> output order 0x00..0x0F at 1 beat/cycle after the first, with count steady at 1. Repeat with DEPTH=3 to exercise pointer wrap.
- Hold 0x5A at the head with deq_ready=0 for 5 cycles -> deq_bits stays 0x5A, deq_valid stays 1.
- With two beats held, assert reset for 1 cycle -> count=0, deq_valid=0. The next enq of 0x77 is the first beat dequeued.
- Flow variant (TL_CHANNEL_QUEUE_FLOW_EN defined), empty queue, enq 0x3C with deq_ready=1 -> deq_valid=1 and deq_bits=0x3C in the same cycle, count remains 0.

Source files
------------

// File: rtl/tl_channel_queue.sv
// rtl/tl_channel_queue.sv - ready/valid channel FIFO with occupancy count
// Optional same-cycle flow-through while empty: define TL_CHANNEL_QUEUE_FLOW_EN.
module tl_channel_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [WIDTH-1:0] enq_bits,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [WIDTH-1:0] deq_bits,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] storage_q [DEPTH];
    logic [PW-1:0]    enq_ptr_q, enq_ptr_d;
    logic [PW-1:0]    deq_ptr_q, deq_ptr_d;
    logic             maybe_full_q, maybe_full_d;

    logic ptr_match, empty, full;
    logic enq_fire, deq_fire, flow_pass, do_enq, do_deq;

    // Explicit wrap so a non-power-of-two DEPTH never indexes past the array.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ptr_match = (enq_ptr_q == deq_ptr_q);
    assign empty     = ptr_match & ~maybe_full_q;
    assign full      = ptr_match & maybe_full_q;
    assign enq_ready = ~full;
    assign enq_fire  = enq_valid & enq_ready;

`ifdef TL_CHANNEL_QUEUE_FLOW_EN
    assign flow_pass = empty & enq_valid & deq_ready;
    assign deq_valid = ~empty | enq_valid;
    assign deq_bits  = empty ? enq_bits : storage_q[deq_ptr_q];
`else
    assign flow_pass = 1'b0;
    assign deq_valid = ~empty;
    assign deq_bits  = storage_q[deq_ptr_q];
`endif

    assign deq_fire = deq_valid & deq_ready;
    // A flow-through beat bypasses storage entirely.
    assign do_enq   = enq_fire & ~flow_pass;
    assign do_deq   = deq_fire & ~flow_pass;

    always_comb begin
        enq_ptr_d    = enq_ptr_q;
        deq_ptr_d    = deq_ptr_q;
        maybe_full_d = maybe_full_q;
        if (do_enq) begin
            enq_ptr_d = ptr_inc(enq_ptr_q);
        end
        if (do_deq) begin
            deq_ptr_d = ptr_inc(deq_ptr_q);
        end
        if (do_enq != do_deq) begin
            maybe_full_d = do_enq;
        end
    end

    always_comb begin
        count = '0;
        if (ptr_match) begin
            count = maybe_full_q ? CW'(DEPTH) : '0;
        end else if (enq_ptr_q > deq_ptr_q) begin
            count = CW'(enq_ptr_q) - CW'(deq_ptr_q);
        end else begin
            count = CW'(DEPTH) - CW'(deq_ptr_q) + CW'(enq_ptr_q);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            enq_ptr_q    <= '0;
            deq_ptr_q    <= '0;
            maybe_full_q <= 1'b0;
        end else begin
            enq_ptr_q    <= enq_ptr_d;
            deq_ptr_q    <= deq_ptr_d;
            maybe_full_q <= maybe_full_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_enq) begin
            storage_q[enq_ptr_q] <= enq_bits;
        end
    end

endmodule
